// File: rtl/udma_hyper_pkg.sv
// Shared types for the hyperbus transaction scheduler: descriptor layout and FSM states.
package udma_hyper_pkg;

    localparam int unsigned L2_AWIDTH_NOAL = 19;
    localparam int unsigned TRANS_SIZE     = 20;

    typedef struct packed {
        logic                      rw;
        logic                      addr_space;
        logic                      burst_type;
        logic [31:0]               hyper_addr;
        logic [L2_AWIDTH_NOAL-1:0] l2_start_addr;
        logic [TRANS_SIZE-1:0]     size;
        logic                      twd_ext_act;
        logic                      twd_l2_act;
        logic [TRANS_SIZE-1:0]     twd_count;
        logic [TRANS_SIZE-1:0]     twd_stride;
    } hyper_trans_desc_t;

    localparam int unsigned HYPER_DESC_W = $bits(hyper_trans_desc_t);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } sched_state_e;

endpackage

// File: rtl/udma_hyper_desc_fifo.sv
// In-order descriptor queue: circular storage, separate occupancy count, overflow pulse.
module udma_hyper_desc_fifo
    import udma_hyper_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic [HYPER_DESC_W-1:0] data_i,
    input  logic                    pop_i,
    output logic [HYPER_DESC_W-1:0] data_o,
    output logic [CW-1:0]           count_o,
    output logic                    ready_o,
    output logic                    ovf_o
);

    logic [HYPER_DESC_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]           rd_ptr_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    full;
    logic                    push_acc;
    logic                    pop_acc;

    // A flush discards any push arriving in the same cycle.
    assign full     = (count_q == CW'(DEPTH));
    assign push_acc = push_i & ~full & ~clr_i;
    assign pop_acc  = pop_i & (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (clr_i) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (pop_acc) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push_acc) - CW'(pop_acc);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ready_o = ~full;
    assign ovf_o   = push_i & full;

endmodule

// File: rtl/udma_hyper_trans_sched.sv
// Issues queued hyperbus descriptors one at a time, waiting for completion between them.
// Optional watchdog on the in-flight transaction: define UDMA_HYPER_SCHED_TIMEOUT_EN.
module udma_hyper_trans_sched
    import udma_hyper_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    trans_valid_i,
    input  logic [HYPER_DESC_W-1:0] trans_desc_i,
    output logic                    trans_ready_o,
    output logic [$clog2(DEPTH):0]  nb_trans_waiting_o,
    output logic                    busy_o,
    output logic                    ovf_o,
    output logic                    phy_valid_o,
    output logic [HYPER_DESC_W-1:0] phy_desc_o,
    input  logic                    phy_ready_i,
    input  logic                    phy_done_i,
    output logic                    err_timeout_o
);

    sched_state_e state_q;
    sched_state_e state_d;
    logic         pop;
    logic         timeout;

    udma_hyper_desc_fifo #(
        .DEPTH (DEPTH)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (trans_valid_i),
        .data_i  (trans_desc_i),
        .pop_i   (pop),
        .data_o  (phy_desc_o),
        .count_o (nb_trans_waiting_o),
        .ready_o (trans_ready_o),
        .ovf_o   (ovf_o)
    );

`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wd_cnt_q;

    // Counts cycles spent in WAIT_DONE; zero on the first cycle of every wait.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (state_q != WAIT_DONE) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + TW'(1);
        end
    end

    assign timeout = (state_q == WAIT_DONE) && (wd_cnt_q == TW'(TIMEOUT_CYC)) && !phy_done_i;
`else
    assign timeout = 1'b0;
`endif

    assign err_timeout_o = timeout;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush only cancels an offer the controller has not yet taken.
    always_comb begin
        state_d     = state_q;
        phy_valid_o = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if ((nb_trans_waiting_o != '0) && !clr_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                phy_valid_o = 1'b1;
                if (phy_ready_i) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end else if (clr_i) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (phy_done_i || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_udma_hyper_trans_sched.sv
// Self-checking bench for udma_hyper_trans_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_udma_hyper_trans_sched;
    import udma_hyper_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TO    = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic                    trans_valid;
    hyper_trans_desc_t       trans_desc;
    logic                    trans_ready;
    logic [CW-1:0]           nb_waiting;
    logic                    busy;
    logic                    ovf;
    logic                    phy_valid;
    logic [HYPER_DESC_W-1:0] phy_desc;
    logic                    phy_ready;
    logic                    phy_done;
    logic                    err_timeout;

    always #5 clk = ~clk;

    udma_hyper_trans_sched #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clr_i              (clr),
        .trans_valid_i      (trans_valid),
        .trans_desc_i       (trans_desc),
        .trans_ready_o      (trans_ready),
        .nb_trans_waiting_o (nb_waiting),
        .busy_o             (busy),
        .ovf_o              (ovf),
        .phy_valid_o        (phy_valid),
        .phy_desc_o         (phy_desc),
        .phy_ready_i        (phy_ready),
        .phy_done_i         (phy_done),
        .err_timeout_o      (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: descriptors accepted but not yet handed to the controller,
    // plus whether one is outstanding at the controller and for how long.
    hyper_trans_desc_t mq[$];
    bit                inflight = 1'b0;
    int                age = 0;

    // Values observed mid-cycle and the model's view of that same cycle.
    logic              o_valid, o_ready, o_busy, o_ovf, o_err;
    hyper_trans_desc_t o_desc;
    logic [CW-1:0]     o_cnt;
    int                e_cnt;
    bit                e_ovf;
    bit                hs;
    bit                hs_exp_ok;
    hyper_trans_desc_t hs_exp;

    function automatic hyper_trans_desc_t rand_desc();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[HYPER_DESC_W-1:0];
    endfunction

    // Drives one clock cycle, samples outputs at the falling edge, then advances the model.
    task automatic cycle(input bit v, input hyper_trans_desc_t d, input bit rdy, input bit dn, input bit cl);
        bit                push;
        hyper_trans_desc_t tmp;
        trans_valid = v;
        trans_desc  = d;
        phy_ready   = rdy;
        phy_done    = dn;
        clr         = cl;
        @(negedge clk);
        o_valid   = phy_valid;
        o_ready   = trans_ready;
        o_busy    = busy;
        o_ovf     = ovf;
        o_err     = err_timeout;
        o_desc    = phy_desc;
        o_cnt     = nb_waiting;
        e_cnt     = mq.size();
        e_ovf     = v && (mq.size() == DEPTH);
        hs        = o_valid && rdy;
        hs_exp_ok = hs && (mq.size() > 0);
        if (hs_exp_ok) hs_exp = mq[0];
        @(posedge clk);
        #1;
        push = v && (mq.size() != DEPTH) && !cl;
        if (hs && mq.size() > 0) tmp = mq.pop_front();
        if (cl) mq.delete();
        if (push) mq.push_back(d);
        if (inflight && dn) inflight = 1'b0;
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
        else if (inflight) begin
            if (age == TO) inflight = 1'b0;
            else age++;
        end
`endif
        if (hs) begin
            inflight = 1'b1;
            age      = 0;
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;
        mq.delete();
        inflight = 1'b0;
        idle(1'b0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b want 1", o_ready); end
        checks++; if (o_cnt !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", o_cnt); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", o_valid); end
        checks++; if (o_ovf !== 1'b0 || o_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: ovf %0b err %0b want 0 0", o_ovf, o_err); end
    endtask

    task automatic test_single();
        hyper_trans_desc_t a;
        a = rand_desc();
        cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c0_valid: got %0b want 0", o_valid); end
        idle(1'b0);
        checks++; if (o_valid !== 1'b0 || o_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL single_c1: valid %0b cnt %0d want 0 1", o_valid, o_cnt); end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checks++; if (o_valid !== 1'b1 || o_desc !== a) begin errors++; $display("[TB] FAIL single_hold%0d: valid %0b desc %h want 1 %h", i, o_valid, o_desc, a); end
        end
        idle(1'b1);
        checks++; if (o_valid !== 1'b1 || o_desc !== a) begin errors++; $display("[TB] FAIL single_hs: valid %0b desc %h want 1 %h", o_valid, o_desc, a); end
        idle(1'b0);
        checks++; if (o_cnt !== '0 || o_busy !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_wait: cnt %0d busy %0b valid %0b want 0 1 0", o_cnt, o_busy, o_valid); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: busy %0b want 0", o_busy); end
    endtask

    task automatic test_fill();
        hyper_trans_desc_t d[10];
        bit                got;
        for (int i = 0; i < 10; i++) d[i] = rand_desc();
        for (int i = 0; i < 8; i++) cycle(1'b1, d[i], 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        checks++; if (o_valid !== 1'b1 || o_desc !== d[0]) begin errors++; $display("[TB] FAIL fill_first: valid %0b desc %h want 1 %h", o_valid, o_desc, d[0]); end
        idle(1'b0);
        checks++; if (o_cnt !== CW'(7) || o_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_seven: cnt %0d ready %0b want 7 1", o_cnt, o_ready); end
        cycle(1'b1, d[8], 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checks++; if (o_cnt !== CW'(8) || o_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: cnt %0d ready %0b want 8 0", o_cnt, o_ready); end
        cycle(1'b1, d[9], 1'b0, 1'b0, 1'b0);
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("[TB] FAIL fill_ovf: got %0b want 1", o_ovf); end
        idle(1'b0);
        checks++; if (o_ovf !== 1'b0 || o_cnt !== CW'(8)) begin errors++; $display("[TB] FAIL fill_after_ovf: ovf %0b cnt %0d want 0 8", o_ovf, o_cnt); end
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
            got = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                idle(1'b1);
                if (o_valid) begin
                    got = 1'b1;
                    checks++; if (o_desc !== d[k]) begin errors++; $display("[TB] FAIL fill_order%0d: got %h want %h", k, o_desc, d[k]); end
                end
            end
            if (!got) begin checks++; errors++; $display("[TB] FAIL fill_issue%0d: no offer within bound, want one", k); end
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
    endtask

    task automatic test_back_to_back();
        int  pushed = 0;
        int  issued = 0;
        bit  v, rdy, dn, pre_inflight;
        for (int c = 0; c < 800 && issued < 20; c++) begin
            v   = (pushed < 20) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            dn  = inflight && ($urandom_range(0, 2) == 0);
            pre_inflight = inflight;
            if (v && mq.size() != DEPTH) pushed++;
            cycle(v, rand_desc(), rdy, dn, 1'b0);
            checks++; if (o_cnt !== CW'(e_cnt) || o_cnt > CW'(DEPTH)) begin errors++; $display("[TB] FAIL wrap_count c%0d: got %0d want %0d", c, o_cnt, e_cnt); end
            checks++; if (o_ready !== (e_cnt != DEPTH) || o_ovf !== e_ovf) begin errors++; $display("[TB] FAIL wrap_flags c%0d: ready %0b ovf %0b want %0b %0b", c, o_ready, o_ovf, e_cnt != DEPTH, e_ovf); end
            if (pre_inflight) begin
                checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_inflight c%0d: valid %0b busy %0b want 0 1", c, o_valid, o_busy); end
            end
            if (hs) begin
                issued++;
                checks++; if (!hs_exp_ok || o_desc !== hs_exp) begin errors++; $display("[TB] FAIL wrap_order%0d: got %h want %h", issued, o_desc, hs_exp); end
            end
        end
        checks++; if (issued != 20) begin errors++; $display("[TB] FAIL wrap_total: issued %0d want 20", issued); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
    endtask

    task automatic test_clear();
        hyper_trans_desc_t d[4];
        for (int i = 0; i < 4; i++) d[i] = rand_desc();
        for (int i = 0; i < 4; i++) cycle(1'b1, d[i], 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        checks++; if (o_valid !== 1'b1 || o_desc !== d[0]) begin errors++; $display("[TB] FAIL clr_hs: valid %0b desc %h want 1 %h", o_valid, o_desc, d[0]); end
        idle(1'b0);
        checks++; if (o_cnt !== CW'(3) || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_before: cnt %0d busy %0b want 3 1", o_cnt, o_busy); end
        cycle(1'b1, rand_desc(), 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        checks++; if (o_cnt !== '0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_after: cnt %0d busy %0b want 0 1", o_cnt, o_busy); end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_idle%0d: valid %0b busy %0b want 0 0", i, o_valid, o_busy); end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, rand_desc(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_desc(), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_issue: valid %0b want 1", o_valid); end
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
        mq.delete();
        inflight = 1'b0;
        idle(1'b0);
        checks++; if (o_valid !== 1'b0 || o_cnt !== '0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after: valid %0b cnt %0d ready %0b busy %0b want 0 0 1 0", o_valid, o_cnt, o_ready, o_busy); end
    endtask

`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        hyper_trans_desc_t d0, d1;
        d0 = rand_desc();
        d1 = rand_desc();
        cycle(1'b1, d0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, d1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        checks++; if (o_valid !== 1'b1 || o_desc !== d0) begin errors++; $display("[TB] FAIL to_hs: valid %0b desc %h want 1 %h", o_valid, o_desc, d0); end
        for (int k = 0; k <= TO + 2; k++) begin
            idle(1'b0);
            checks++; if (o_err !== (k == TO)) begin errors++; $display("[TB] FAIL to_err%0d: got %0b want %0b", k, o_err, k == TO); end
            if (k == TO + 2) begin
                checks++; if (o_valid !== 1'b1 || o_desc !== d1) begin errors++; $display("[TB] FAIL to_next: valid %0b desc %h want 1 %h", o_valid, o_desc, d1); end
            end
        end
        idle(1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        trans_valid = 1'b0;
        trans_desc  = '0;
        phy_ready   = 1'b0;
        phy_done    = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_clear();
        test_reset_mid();
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "[TB] time bound exceeded");
    end

endmodule

// File: doc/udma_hyper_trans_sched.md
Name: udma_hyper_trans_sched

Overview:
Transaction scheduler between the hyperbus register interface and the hyperbus controller/PHY. It snapshots each configured transaction descriptor when software kicks an RX/TX, queues up to DEPTH descriptors in order, and issues them one at a time to the controller. A new transaction starts only after the previous one reports completion. It reports queue occupancy and busy status back for the STATUS register.

Parameters:
DEPTH, 8, number of queued descriptors (power of two, >=2)
TIMEOUT_CYC, 65535, watchdog limit in clk_i cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
clr_i  in  1  flush request for pending (not in-flight) descriptors
trans_valid_i  in  1  descriptor push request from the register interface
trans_desc_i  in  HYPER_DESC_W  packed hyper_trans_desc_t: rw, addr_space, burst_type, hyper_addr[31:0], l2 startaddr, size, 2D ext/l2 act/count/stride
trans_ready_o  out  1  queue can accept a descriptor
nb_trans_waiting_o  out  $clog2(DEPTH)+1  number of queued descriptors
busy_o  out  1  a transaction is being issued or is in flight
ovf_o  out  1  one-cycle pulse: push attempted while full
phy_valid_o  out  1  descriptor offered to the controller
phy_desc_o  out  HYPER_DESC_W  head descriptor
phy_ready_i  in  1  controller accepts the descriptor
phy_done_i  in  1  one-cycle pulse: in-flight transaction complete
err_timeout_o  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (rst_ni=0 at posedge): count=0, rd/wr pointers=0, state=IDLE, all outputs 0 except trans_ready_o=1. Reset mid-transaction discards the in-flight and queued descriptors.
- FIFO: circular buffer with pointers of $clog2(DEPTH) bits that wrap naturally. The count is held in a separate $clog2(DEPTH)+1-bit register.
- trans_ready_o = (count != DEPTH). It is based on the registered count only.
- Push happens when trans_valid_i & trans_ready_o. The descriptor is written at wr_ptr and becomes visible in the next cycle.
- Push while full: the descriptor is dropped and ovf_o pulses in the same cycle. This also applies when a pop occurs in that same cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states:
  - IDLE: busy_o=0. If count != 0, go to ISSUE.
  - ISSUE: phy_valid_o=1 and phy_desc_o=head entry. The descriptor is held stable until phy_ready_i. On phy_ready_i: pop and go to WAIT_DONE.
  - WAIT_DONE: phy_valid_o=0. On phy_done_i go to IDLE. This gives one bubble cycle between transactions.
- phy_done_i is ignored outside WAIT_DONE.
- busy_o = (state != IDLE).
- Latency: a push accepted in cycle N into an empty, idle queue gives phy_valid_o=1 in cycle N+2.
- clr_i:
  - Sets count to 0 and rd_ptr to wr_ptr at the next edge.
  - It does not abort an in-flight (WAIT_DONE) transaction.
  - If asserted in ISSUE without phy_ready_i, the FSM returns to IDLE and phy_valid_o drops.
  - If asserted in ISSUE with phy_ready_i, the handshake completes and the FSM enters WAIT_DONE.
  - A push in the same cycle as clr_i is discarded.
- nb_trans_waiting_o = count. The in-flight transaction is not counted.

Optional Feature:
UDMA_HYPER_SCHED_TIMEOUT_EN
- Defined:
  - A counter of $clog2(TIMEOUT_CYC+1) bits clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - When it reaches TIMEOUT_CYC without phy_done_i, err_timeout_o pulses for one cycle and the FSM returns to IDLE. The next queued descriptor is then issued.
  - If phy_done_i arrives in the same cycle as the limit, the transaction counts as complete and there is no error.
- Undefined: no counter, err_timeout_o tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package udma_hyper_pkg holds:
  - the hyper_trans_desc_t packed struct and HYPER_DESC_W;
  - the FSM enum sched_state_e {IDLE, ISSUE, WAIT_DONE};
  - the L2_AWIDTH_NOAL and TRANS_SIZE constants the struct uses.
- One sub-module, udma_hyper_desc_fifo, holds the storage, pointers, count, full flag and overflow pulse. The scheduler top holds the FSM and watchdog.

Test Plan:
- Single transaction: push A in cycle 0 -> phy_valid_o=1 in cycle 2 with phy_desc_o=A. Hold phy_ready_i=0 for 3 cycles -> descriptor stable. phy_ready_i=1 -> count 0, busy_o=1. phy_done_i -> busy_o=0 next cycle.
- Fill: push 8 descriptors while the controller stalls -> the first is issued, 7 stay queued, and one more push gives count=8, trans_ready_o=0. A 10th push -> ovf_o=1 for one cycle, count stays 8. Issue order matches push order.
- Pointer wrap: 20 push/complete cycles with interleaved simultaneous push and pop -> all 20 descriptors issued in order, count never exceeds 8.
- clr_i during WAIT_DONE with 3 queued -> count=0 next cycle, in-flight completes on phy_done_i, then the FSM stays IDLE.
- Reset mid-ISSUE (rst_ni=0 for one cycle) -> phy_valid_o=0, count=0, trans_ready_o=1 after the edge.
- With UDMA_HYPER_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: withhold phy_done_i -> err_timeout_o pulses 16 cycles after WAIT_DONE entry, and the next descriptor is issued two cycles later.
